fetch_unit: RTL and testbench

Instruction fetch and decode-register stage of the four-phase multicycle core. It holds the program counter and the instruction register, and it drives the shared memory address bus. It splits the latched instruction into the fields that feed the control FSM (opcode) and the datapath (register indices, immediate). It consumes the control FSM's phase strobes (`pc_flag`, `instruction_flag`, `change_address_flag`) and its PC-source selects (`M2`, `M13`).

---
 rtl/fetch_unit.sv | 62 ++++++
 tb/tb_fetch_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction register and field decode, plus the shared memory address mux
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_flag,
  input  logic              instruction_flag,
  input  logic              change_address_flag,
  input  logic              M2,
  input  logic              M13,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [15:0]       imm,
  output logic [DATA_W-1:0] imm_sext,
  output logic [31:0]       instr_count
);
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [31:0]       r_cnt;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_jmp;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_next;
  // branch offset is sign-extended, jump target zero-extended; both resized to the PC width
  always_comb begin
    w_off     = ADDR_W'($signed(imm));
    w_jmp     = ADDR_W'(imm);
    w_pc_inc  = r_pc + ADDR_W'(1);
    w_pc_next = M2 ? (M13 ? w_jmp : w_pc_inc + w_off) : w_pc_inc;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc  <= ADDR_W'(RESET_PC);
      r_ir  <= '0;
      r_cnt <= '0;
    end else begin
      if (instruction_flag) r_ir <= mem_rdata;
      if (pc_flag) begin
        r_pc  <= w_pc_next;
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end
  assign pc          = r_pc;
  assign instr_count = r_cnt;
  assign mem_addr    = change_address_flag ? data_addr : r_pc;
  assign opcode      = r_ir[31:28];
  assign rd          = r_ir[27:24];
  assign rs          = r_ir[23:20];
  assign rt          = r_ir[19:16];
  assign imm         = r_ir[15:0];
  assign imm_sext    = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a behavioural PC/IR model
module tb_fetch_unit;
  localparam int AW = 16;
  localparam int DW = 32;
  logic clk = 0, reset = 1;
  logic pc_flag = 0, instruction_flag = 0, change_address_flag = 0, M2 = 0, M13 = 0;
  logic [AW-1:0] data_addr = '0, mem_addr, pc;
  logic [DW-1:0] mem_rdata, imm_sext;
  logic [3:0] opcode, rd, rs, rt;
  logic [15:0] imm;
  logic [31:0] instr_count;
  logic ovr = 0;
  logic [31:0] ovr_val = 0;
  int n_chk = 0, n_err = 0;
  int m_pc = 16;
  logic [31:0] m_ir = 0;
  logic [31:0] m_cnt = 0;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(32'h10)) dut (
    .clk(clk), .reset(reset), .pc_flag(pc_flag), .instruction_flag(instruction_flag),
    .change_address_flag(change_address_flag), .M2(M2), .M13(M13), .data_addr(data_addr),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .pc(pc), .opcode(opcode), .rd(rd), .rs(rs),
    .rt(rt), .imm(imm), .imm_sext(imm_sext), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  assign mem_rdata = ovr ? ovr_val : word_at(int'(mem_addr));

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", 64'(pc), 64'(m_pc));
    chk("mem_addr", 64'(mem_addr), change_address_flag ? 64'(data_addr) : 64'(m_pc));
    chk("ir_fields", 64'({opcode, rd, rs, rt, imm}), 64'(m_ir));
    chk("imm_sext", 64'(imm_sext), 64'(m_ir[15] ? {16'hFFFF, m_ir[15:0]} : {16'h0000, m_ir[15:0]}));
    chk("instr_count", 64'(instr_count), 64'(m_cnt));
  endtask

  task automatic model_reset();
    m_pc = 16;
    m_ir = 0;
    m_cnt = 0;
  endtask

  task automatic step(logic pf, logic inf, logic cfl, logic m2, logic m13);
    int imm_old, addr, off;
    pc_flag = pf; instruction_flag = inf; change_address_flag = cfl; M2 = m2; M13 = m13;
    if (!reset) begin
      imm_old = int'(m_ir[15:0]);
      addr = cfl ? int'(data_addr) : m_pc;
      if (inf) m_ir = ovr ? ovr_val : word_at(addr);
      if (pf) begin
        m_cnt = m_cnt + 1;
        off = imm_old >= 32768 ? imm_old - 65536 : imm_old;
        if (!m2) m_pc = (m_pc + 1) & 'hFFFF;
        else if (m13) m_pc = imm_old;
        else m_pc = (m_pc + 1 + off) & 'hFFFF;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic load(logic [31:0] v);
    ovr = 1;
    ovr_val = v;
    step(0, 1, 0, 0, 0);
    ovr = 0;
  endtask

  task automatic jump(logic [15:0] a);
    load({16'h0000, a});
    step(1, 0, 0, 1, 1);
  endtask

  initial begin
    #1;
    for (int i = 0; i < 6; i++) begin
      step(1'($urandom), 1'($urandom), 0, 1'($urandom), 1'($urandom));
      chk("rst_hold_pc", 64'(pc), 64'h10);
      chk("rst_hold_cnt", 64'(instr_count), 64'h0);
    end
    reset = 0;
    step(1, 0, 0, 0, 0);
    chk("seq1", 64'(pc), 64'h11);
    step(1, 0, 0, 0, 0);
    chk("seq2", 64'(pc), 64'h12);
    load(32'h4123ABCD);
    chk("dec_op", 64'(opcode), 64'h4);
    chk("dec_rd", 64'(rd), 64'h1);
    chk("dec_rs", 64'(rs), 64'h2);
    chk("dec_rt", 64'(rt), 64'h3);
    chk("dec_imm", 64'(imm), 64'hABCD);
    chk("dec_sext", 64'(imm_sext), 64'hFFFFABCD);
    jump(16'h0100);
    chk("jmp_100", 64'(pc), 64'h100);
    load(32'h0000FFFE);
    step(1, 0, 0, 1, 0);
    chk("branch_neg", 64'(pc), 64'hFF);
    load(32'h00000040);
    step(1, 0, 0, 1, 1);
    chk("jump_40", 64'(pc), 64'h40);
    step(1, 0, 0, 0, 1);
    chk("seq_m13", 64'(pc), 64'h41);
    jump(16'hFFFF);
    data_addr = 16'h1234;
    change_address_flag = 1;
    #1;
    chk("mux_data", 64'(mem_addr), 64'h1234);
    change_address_flag = 0;
    #1;
    chk("mux_pc", 64'(mem_addr), 64'hFFFF);
    step(1, 0, 0, 0, 0);
    chk("pc_wrap", 64'(pc), 64'h0);
    jump(16'h0005);
    load(32'h00000003);
    step(1, 1, 0, 1, 0);
    chk("simul_pc", 64'(pc), 64'h9);
    chk("simul_ir", 64'({opcode, rd, rs, rt, imm}), 64'(word_at(5)));
    for (int i = 0; i < 400; i++) begin
      ovr = ($urandom_range(0, 3) == 0);
      ovr_val = $urandom;
      data_addr = 16'($urandom);
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    ovr = 0;
    #2;
    reset = 1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 0;
    for (int i = 0; i < 7; i++) begin
      data_addr = 16'($urandom);
      step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    chk("retired7", 64'(instr_count), 64'h7);
    pc_flag = 1;
    instruction_flag = 1;
    #2;
    reset = 1;
    model_reset();
    #1;
    chk("async_pc", 64'(pc), 64'h10);
    chk("async_cnt", 64'(instr_count), 64'h0);
    chk("async_ir", 64'({opcode, rd, rs, rt, imm}), 64'h0);
    @(posedge clk);
    #1;
    check_all();
    reset = 0;
    step(1, 0, 0, 0, 0);
    chk("post_rst_seq", 64'(pc), 64'h11);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
